// File: rtl/riscv_v_i2v_packer_pkg.sv
// Shared vector-unit definitions: widths, osize one-hot indices,
// the packed vector word and the i2v packer state encoding.
package riscv_v_pkg;

  localparam int RISCV_V_DATA_WIDTH = 128;
  localparam int RISCV_V_NUM_BYTES_DATA = RISCV_V_DATA_WIDTH / 8;
  localparam int RISCV_DATA_WIDTH = 32;

  localparam int OSIZE_BYTE = 0;
  localparam int OSIZE_WORD = 1;
  localparam int OSIZE_DWORD = 2;
  localparam int OSIZE_QWORD = 3;
  localparam int OSIZE_DQWORD = 4;
  localparam int RISCV_V_NUM_VALID_OSIZES = 5;

  typedef struct packed {
    logic [RISCV_V_DATA_WIDTH-1:0] data;
    logic [RISCV_V_NUM_BYTES_DATA-1:0] byte_en;
  } vec_word_t;

  typedef enum logic [1:0] {
    PK_IDLE,
    PK_FILL,
    PK_OUT
  } pack_state_t;

endpackage

// File: rtl/riscv_v_i2v_packer_if.sv
// Element-in / vector-word-out handshake bundle for the i2v packer.
// master drives elements and consumes words; slave is the packer.
interface riscv_v_i2v_packer_if #(
  parameter int DATA_WIDTH = 128,
  parameter int XLEN = 32
);
  import riscv_v_pkg::*;

  logic in_valid;
  logic in_ready;
  logic [XLEN-1:0] in_data;
  logic [RISCV_V_NUM_VALID_OSIZES-1:0] in_osize;
  logic in_last;
  logic out_valid;
  logic out_ready;
  logic [DATA_WIDTH+DATA_WIDTH/8-1:0] out_data;
  logic [4:0] elem_count;

  modport master (
    output in_valid, in_data, in_osize, in_last,
    output out_ready,
    input in_ready, out_valid, out_data, elem_count
  );

  modport slave (
    input in_valid, in_data, in_osize, in_last,
    input out_ready,
    output in_ready, out_valid, out_data, elem_count
  );
endinterface

// File: rtl/riscv_v_i2v_packer_osize_decode.sv
// One-hot osize to element geometry; qword and dqword fold to
// dword because scalar operands are at most 32 bits wide.
module riscv_v_osize_decode
  import riscv_v_pkg::*;
(
  input  logic [RISCV_V_NUM_VALID_OSIZES-1:0] osize,
  output logic [2:0] elem_bytes,
  output logic [1:0] elem_shift,
  output logic [4:0] elems_per_word
);

  always_comb begin
    elem_bytes = 3'd4;
    elem_shift = 2'd2;
    elems_per_word = 5'd4;
    unique case (1'b1)
      osize[OSIZE_BYTE]: begin
        elem_bytes = 3'd1;
        elem_shift = 2'd0;
        elems_per_word = 5'd16;
      end
      osize[OSIZE_WORD]: begin
        elem_bytes = 3'd2;
        elem_shift = 2'd1;
        elems_per_word = 5'd8;
      end
      osize[OSIZE_DWORD],
      osize[OSIZE_QWORD],
      osize[OSIZE_DQWORD]: begin
        elem_bytes = 3'd4;
        elem_shift = 2'd2;
        elems_per_word = 5'd4;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_v_i2v_packer.sv
// Packs a stream of truncated scalar elements into one vector
// word with byte enables and hands it to vector writeback.
module riscv_v_i2v_packer
  import riscv_v_pkg::*;
#(
  parameter int DATA_WIDTH = RISCV_V_DATA_WIDTH,
  parameter int XLEN = RISCV_DATA_WIDTH
) (
  input logic clk,
  input logic rst,
  input logic flush,
  riscv_v_i2v_packer_if.slave bus
);

  pack_state_t state_q, state_n;
  vec_word_t word_q, word_n;
  logic [4:0] count_q, count_n;
  logic [RISCV_V_NUM_VALID_OSIZES-1:0] osize_q, osize_n;

  logic [RISCV_V_NUM_VALID_OSIZES-1:0] sel_osize;
  logic [2:0] elem_bytes;
  logic [1:0] elem_shift;
  logic [4:0] epw;
  logic [XLEN-1:0] din;
  logic accept;
  logic [3:0] byte_off;
  logic [3:0] bidx;

  // The first element of a group decides the geometry.
  assign sel_osize = (state_q == PK_IDLE) ? bus.in_osize : osize_q;

  riscv_v_osize_decode u_dec (
    .osize(sel_osize),
    .elem_bytes(elem_bytes),
    .elem_shift(elem_shift),
    .elems_per_word(epw)
  );

  assign din = bus.in_data;
  assign bus.in_ready = (state_q != PK_OUT) & ~rst;
  assign bus.out_valid = (state_q == PK_OUT);
  assign bus.out_data = {word_q.data[DATA_WIDTH-1:0],
                         word_q.byte_en[DATA_WIDTH/8-1:0]};
  assign bus.elem_count = count_q;
  assign accept = bus.in_valid & bus.in_ready;

  always_comb begin
    state_n = state_q;
    word_n = word_q;
    count_n = count_q;
    osize_n = osize_q;
    byte_off = 4'(count_q << elem_shift);
    bidx = '0;
    if (accept) begin
      for (int i = 0; i < 4; i++) begin
        if (i < int'(elem_bytes)) begin
          bidx = byte_off + 4'(i);
          word_n.data[{bidx, 3'b000} +: 8] = din[i*8 +: 8];
          word_n.byte_en[bidx] = 1'b1;
        end
      end
      count_n = count_q + 5'd1;
      if (state_q == PK_IDLE) osize_n = bus.in_osize;
      if (count_n == epw || bus.in_last) state_n = PK_OUT;
      else state_n = PK_FILL;
    end
    if (state_q == PK_OUT && bus.out_ready) begin
      state_n = PK_IDLE;
      word_n = '0;
      count_n = '0;
      osize_n = '0;
    end
    // Flush outranks both acceptance and drain.
    if (flush) begin
      state_n = PK_IDLE;
      word_n = '0;
      count_n = '0;
      osize_n = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PK_IDLE;
      word_q <= '0;
      count_q <= '0;
      osize_q <= '0;
    end else begin
      state_q <= state_n;
      word_q <= word_n;
      count_q <= count_n;
      osize_q <= osize_n;
    end
  end

endmodule

// File: tb/tb_riscv_v_i2v_packer.sv
// Scoreboard bench for the i2v packer: directed scenarios plus
// randomized groups checked against a queue-based packing model.
module tb_riscv_v_i2v_packer;
  import riscv_v_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int total = 0;
  int bad = 0;
  bit bp_rand = 1'b0;

  riscv_v_i2v_packer_if #(.DATA_WIDTH(128), .XLEN(32)) bus ();

  riscv_v_i2v_packer #(.DATA_WIDTH(128), .XLEN(32)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  logic [143:0] expq[$];
  logic [31:0] grp[$];
  logic [4:0] grp_os;

  task automatic chk(input string nm, input logic [143:0] act,
                     input logic [143:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int esize(input logic [4:0] os);
    if (os[OSIZE_BYTE]) return 1;
    if (os[OSIZE_WORD]) return 2;
    return 4;
  endfunction

  function automatic logic [143:0] mk_word();
    logic [127:0] d;
    logic [15:0] be;
    int e;
    e = esize(grp_os);
    d = '0;
    be = '0;
    foreach (grp[k]) begin
      for (int j = 0; j < e; j++) begin
        d[(k*e+j)*8 +: 8] = grp[k][j*8 +: 8];
        be[k*e+j] = 1'b1;
      end
    end
    return {d, be};
  endfunction

  task automatic model_accept(input logic [31:0] d, input logic [4:0] os,
                              input logic last);
    if (grp.size() == 0) grp_os = os;
    grp.push_back(d);
    if (grp.size() == 16 / esize(grp_os) || last) begin
      expq.push_back(mk_word());
      grp.delete();
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic send(input logic [31:0] d, input logic [4:0] os,
                      input logic last);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_osize = os;
    bus.in_last = last;
    @(negedge clk);
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready stuck at %0b", bus.in_ready);
    end else begin
      model_accept(d, os, last);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [4:0] oh(input int i);
    logic [4:0] v;
    v = 5'd1 << i;
    return v;
  endfunction

  always @(posedge clk) begin
    if (bp_rand) begin
      #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  logic held;
  logic [143:0] held_data;

  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held && bus.out_valid) chk("stable", bus.out_data, held_data);
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %h expected none", bus.out_data);
        end else begin
          chk("word", bus.out_data, expq.pop_front());
        end
        held = 1'b0;
      end else if (bus.out_valid) begin
        held = 1'b1;
        held_data = bus.out_data;
      end else begin
        held = 1'b0;
      end
    end
  end

  logic [127:0] fill_data;
  logic [4:0] os_r;
  int len;
  int n;

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_osize = oh(OSIZE_BYTE);
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    grp_os = '0;
    held = 1'b0;
    held_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 144'(bus.in_ready), 144'(0));
    chk("rst_out_valid", 144'(bus.out_valid), 144'(0));
    chk("rst_out_data", bus.out_data, 144'(0));
    chk("rst_count", 144'(bus.elem_count), 144'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 144'(bus.in_ready), 144'(1));
    @(posedge clk);
    #1;

    // Byte fill with exact timing
    for (int k = 0; k < 16; k++) fill_data[k*8 +: 8] = 8'hA0 + 8'(k);
    for (int k = 0; k < 16; k++)
      send(32'h0 | (32'hA0 + 32'(k)), oh(OSIZE_BYTE), 1'b0);
    @(negedge clk);
    chk("bytefill_valid", 144'(bus.out_valid), 144'(1));
    chk("bytefill_ready_low", 144'(bus.in_ready), 144'(0));
    chk("bytefill_count", 144'(bus.elem_count), 144'(16));
    chk("bytefill_data", bus.out_data, {fill_data, 16'hFFFF});
    @(negedge clk);
    chk("bytefill_ready_back", 144'(bus.in_ready), 144'(1));
    chk("bytefill_count0", 144'(bus.elem_count), 144'(0));
    @(posedge clk);
    #1;

    // Dword with early last
    send(32'h11111111, oh(OSIZE_DWORD), 1'b0);
    send(32'h22222222, oh(OSIZE_DWORD), 1'b1);
    @(negedge clk);
    chk("dword_last", bus.out_data,
        {64'h0, 32'h22222222, 32'h11111111, 16'h00FF});
    @(posedge clk);
    #1;

    // Word truncation, later osize ignored
    send(32'hDEADBEEF, oh(OSIZE_WORD), 1'b0);
    send(32'h12345678, oh(OSIZE_BYTE), 1'b1);
    @(negedge clk);
    chk("word_trunc", bus.out_data,
        {96'h0, 16'h5678, 16'hBEEF, 16'h000F});
    @(posedge clk);
    #1;

    // Backpressure
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send($urandom, oh(OSIZE_DWORD), 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data = 32'hCAFEF00D;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", 144'(bus.out_valid), 144'(1));
      chk("bp_ready", 144'(bus.in_ready), 144'(0));
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_count0", 144'(bus.elem_count), 144'(0));
    chk("bp_drained", 144'(bus.out_valid), 144'(0));
    @(posedge clk);
    #1;

    // Flush mid-group
    for (int k = 0; k < 3; k++) send(32'h50 + 32'(k), oh(OSIZE_BYTE), 1'b0);
    @(negedge clk);
    chk("pre_flush_count", 144'(bus.elem_count), 144'(3));
    @(posedge clk);
    #1;
    flush = 1'b1;
    grp.delete();
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_count", 144'(bus.elem_count), 144'(0));
    chk("flush_no_out", 144'(bus.out_valid), 144'(0));
    @(posedge clk);
    #1;
    send(32'h77, oh(OSIZE_BYTE), 1'b0);
    send(32'h88, oh(OSIZE_BYTE), 1'b1);
    idle(2);

    // Flush while a word is pending
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send($urandom, oh(OSIZE_DWORD), 1'b0);
    flush = 1'b1;
    void'(expq.pop_back());
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", 144'(bus.out_valid), 144'(0));
    chk("flush_out_data", bus.out_data, 144'(0));
    @(posedge clk);
    #1;

    // Async reset mid-group
    send(32'h01020304, oh(OSIZE_WORD), 1'b0);
    send(32'h05060708, oh(OSIZE_WORD), 1'b0);
    #2;
    rst = 1'b1;
    grp.delete();
    #1;
    chk("rst_mid_count", 144'(bus.elem_count), 144'(0));
    chk("rst_mid_data", bus.out_data, 144'(0));
    chk("rst_mid_ready", 144'(bus.in_ready), 144'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Async reset while a word is pending
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send($urandom, oh(OSIZE_QWORD), 1'b0);
    @(negedge clk);
    chk("pre_rst_valid", 144'(bus.out_valid), 144'(1));
    #2;
    rst = 1'b1;
    expq.delete();
    #1;
    chk("rst_out_valid2", 144'(bus.out_valid), 144'(0));
    chk("rst_out_data2", bus.out_data, 144'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    idle(1);

    // Wide osize fold
    for (int k = 0; k < 4; k++) send($urandom, oh(OSIZE_QWORD), 1'b0);
    @(negedge clk);
    chk("qword_be", 144'(bus.out_data[15:0]), 144'(16'hFFFF));
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) send($urandom, oh(OSIZE_DQWORD), 1'b0);
    @(negedge clk);
    chk("dqword_be", 144'(bus.out_data[15:0]), 144'(16'hFFFF));
    @(posedge clk);
    #1;

    // Randomized groups with random backpressure
    bp_rand = 1'b1;
    for (int g = 0; g < 60; g++) begin
      os_r = oh($urandom_range(0, 4));
      n = 16 / esize(os_r);
      len = $urandom_range(1, n);
      for (int k = 0; k < len; k++) begin
        send($urandom, (k == 0) ? os_r : oh($urandom_range(0, 4)),
             (k == len - 1) && (len < n || $urandom_range(0, 1) == 1));
        if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      end
    end
    if (grp.size() != 0) send($urandom, oh(OSIZE_BYTE), 1'b1);
    bp_rand = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 200 && expq.size() != 0; i++) @(negedge clk);
    if (expq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d words left expected 0", expq.size());
    end
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_v_i2v_packer.md
# riscv_v_i2v_packer

Sequential scalar-to-vector packer for the vector permutation path. Accepts a stream of 32-bit integer operands from the scalar pipeline, truncates each to the selected element size, and packs consecutive elements into one 128-bit vector word with per-byte enables. Emits the packed word to the vector register writeback path through a valid/ready handshake. This is the multi-element counterpart of the single-element i2v/v2i moves.

## Interface
- `DATA_WIDTH`, 128, vector data width in bits (`RISCV_V_DATA_WIDTH`).
- `XLEN`, 32, scalar operand width (`RISCV_DATA_WIDTH`).
- `clk`  in  1  clock.
- `rst`  in  1  reset; **asynchronous, active-high**.
- `flush`  in  1  synchronous discard of the partial group and any pending output.
- `in_valid`  in  1  scalar element valid.
- `in_ready`  out  1  packer can accept an element.
- `in_data`  in  XLEN  scalar element; the low element-size bytes are used.
- `in_osize`  in  5  one-hot osize: byte, word, dword, qword, dqword. Sampled on the first element of a group.
- `in_last`  in  1  closes the group after this element.
- `out_valid`  out  1  packed vector word available.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  DATA_WIDTH+DATA_WIDTH/8  packed as {data[127:0], byte_en[15:0]}.
- `elem_count`  out  5  number of elements in the current group (0..16).

## Operation
**State machine**
- IDLE: group empty.
- FILL: at least one element held.
- OUT: `out_valid`=1, waiting for the handshake.

**Element geometry**
- Element byte size E: byte osize → 1, word → 2, dword/qword/dqword → 4. qword and dqword fold to dword, matching the integer osize folding.
- Elements per word: N = 16/E, i.e. 16, 8 or 4.
- Group osize is latched on the first accepted element (IDLE → FILL). `in_osize` is ignored on every later element of the group.

**Element placement**
- Element k of the group is written to data bytes [k·E +: E] from `in_data[8E-1:0]`. Higher bits of `in_data` are discarded; there is no sign extension.
- `byte_en` bits [k·E +: E] are set to 1.
- Unwritten bytes read as 0 with `byte_en`=0.

**Transitions**
- IDLE/FILL → OUT when the accepted element makes count = N, or carries `in_last`=1.
- An `in_last` element arriving in IDLE produces a one-element word: IDLE → OUT directly.
- OUT → IDLE on `out_valid & out_ready`. Data, byte_en, count and latched osize all clear.

**Handshakes**
- `in_ready` = !out_valid & !rst.
- No element is accepted in OUT, so there is no simultaneous fill-and-drain.

**Flush**
- `flush` has priority over every other event.
- Next state is IDLE, `out_valid`=0, and all storage is cleared, even if an element or output handshake fires in the same cycle.

**Reset**
- Forces IDLE, `out_valid`=0, `out_data`=0, `elem_count`=0.
- `in_ready`=0 while `rst` is high.
- Reset mid-group drops the partial group with no output.

## Timing
- An element is accepted on the rising edge where `in_valid & in_ready`.
- `out_valid` rises on the same edge that accepts the completing element, so it is visible in the next cycle. There is no combinational input-to-output path.
- `out_data` and `out_valid` are registered. They stay stable while `out_valid & !out_ready`.
- `in_ready` returns high in the cycle after the output handshake.
- Throughput is N elements per N+1 cycles with `out_ready` held at 1.
- `elem_count` updates on each acceptance edge and reads 0 in the cycle after the output handshake.

## Structure
**Shared package `riscv_v_pkg`** holds:
- `RISCV_V_DATA_WIDTH` and `RISCV_V_NUM_BYTES_DATA`.
- The osize one-hot index constants (BYTE=0 … DQWORD=4) and `RISCV_V_NUM_VALID_OSIZES`.
- A packed struct for the vector word {data, byte_en}.
- The packer state enum.

**Sub-module `riscv_v_osize_decode`** (combinational): converts one-hot osize into the element byte size and elements per word, including the qword/dqword fold. This decode is reusable by other permutation blocks.

## Test plan
- **Byte fill:** osize=byte; 16 elements with `in_data`=0xA0+k, `out_ready`=1 → one word, data bytes = 0xAF…0xA0 (byte k = 0xA0+k), `byte_en`=0xFFFF, `out_valid` one cycle after the 16th acceptance, `in_ready` low exactly 1 cycle.
- **Dword with early last:** osize=dword; 0x11111111, 0x22222222 (`in_last`) → data = 0x…0000_2222_2222_1111_1111, `byte_en`=0x00FF.
- **Word truncation and osize latch:** osize=word; `in_data`=0xDEAD_BEEF, then 0x1234_5678 presented with osize=byte, then `in_last` → halfwords 0xBEEF and 0x5678 at byte offsets 0 and 2, `byte_en`=0x000F.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after a full word → `out_data` stable, `in_ready`=0, input stalls; release → handshake, `elem_count`=0 next cycle.
- **Flush and reset:** flush after 3 byte elements → no output, next group starts at byte 0. Assert `rst` asynchronously mid-group and while `out_valid`=1 → outputs zero immediately, no word emitted.
- **Wide osize fold:** osize=qword and osize=dqword each behave as dword: 4 elements fill a word, `byte_en`=0xFFFF.
